// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : sram_controller
// Description : Runs each 32-bit MEM-stage load/store as two 16-bit SRAM
//               accesses plus a settle wait, and holds ready low meanwhile.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACC_LO = 3'd1;
  localparam logic [2:0] S_ACC_HI = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [31:0] c_base      = 32'(BASE_ADDR);
  localparam logic [3:0]  c_wait_last = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [2:0]  c_after_hi  = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;

  logic [2:0]  r_state;
  logic [2:0]  w_state_next;
  logic [16:0] r_word;
  logic [31:0] r_wdata;
  logic        r_is_write;
  logic [3:0]  r_count;
  logic [31:0] r_rdata;

  logic [31:0] w_offset;
  logic        w_req;
  logic        w_drive;
  logic [15:0] w_dq_out;
  logic        w_unused_bits;

  assign w_req    = rd_en | wr_en;
  // Word index wraps modulo 2^17; out-of-window addresses simply alias.
  assign w_offset = address - c_base;
  assign w_unused_bits = ^{w_offset[31:19], w_offset[1:0]};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_req) w_state_next = S_ACC_LO;
      S_ACC_LO: w_state_next = S_ACC_HI;
      S_ACC_HI: w_state_next = c_after_hi;
      S_WAIT:   if (r_count == c_wait_last) w_state_next = S_DONE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_word     <= 17'd0;
      r_wdata    <= 32'd0;
      r_is_write <= 1'b0;
      r_count    <= 4'd0;
      r_rdata    <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && w_req) begin
        r_word     <= w_offset[18:2];
        r_wdata    <= wdata;
        r_is_write <= wr_en;
      end
      if (r_state == S_WAIT) begin
        r_count <= (r_count == c_wait_last) ? 4'd0 : r_count + 4'd1;
      end
      if (r_state == S_ACC_LO && !r_is_write) r_rdata[15:0]  <= SRAM_DQ;
      if (r_state == S_ACC_HI && !r_is_write) r_rdata[31:16] <= SRAM_DQ;
    end
  end

  // Bus controls come only from registered state so input glitches never reach the pins.
  assign w_drive  = r_is_write & ((r_state == S_ACC_LO) | (r_state == S_ACC_HI));
  assign w_dq_out = (r_state == S_ACC_HI) ? r_wdata[31:16] : r_wdata[15:0];

  assign SRAM_DQ   = w_drive ? w_dq_out : 16'bz;
  assign SRAM_WE_N = ~w_drive;
  assign SRAM_ADDR = {r_word, (r_state == S_ACC_HI)};
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  assign ready = ~(w_req & (r_state != S_DONE));
  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// Testbench for sram_controller: 16-bit SRAM model, reference word memory and
// a read scoreboard; a second instance covers WAIT_CYCLES=0 and address wrap.
module tb_sram_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wr_en, rd_en;
  logic [31:0] address, wdata, rdata;
  logic        ready;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N;

  logic        wr_en0, rd_en0;
  logic [31:0] address0, wdata0, rdata0;
  logic        ready0;
  wire  [15:0] dq0;
  logic [17:0] addr0;
  logic        we0_n, ub0_n, lb0_n, ce0_n, oe0_n;

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .wdata(wdata), .rdata(rdata), .ready(ready), .SRAM_DQ(SRAM_DQ),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N),
    .SRAM_LB_N(SRAM_LB_N), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N)
  );

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .rd_en(rd_en0), .address(address0),
    .wdata(wdata0), .rdata(rdata0), .ready(ready0), .SRAM_DQ(dq0),
    .SRAM_ADDR(addr0), .SRAM_WE_N(we0_n), .SRAM_UB_N(ub0_n),
    .SRAM_LB_N(lb0_n), .SRAM_CE_N(ce0_n), .SRAM_OE_N(oe0_n)
  );

  // SRAM model; a write cycle cut short by reset does not commit.
  logic [15:0] mem [0:262143];
  assign SRAM_DQ = SRAM_WE_N ? mem[SRAM_ADDR] : 16'bz;
  always @(posedge clk) if (SRAM_WE_N === 1'b0 && !rst) mem[SRAM_ADDR] <= SRAM_DQ;

  function automatic logic [15:0] pat(input logic [17:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction
  assign dq0 = we0_n ? pat(addr0) : 16'bz;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] ref_mem [logic [16:0]];
  logic [31:0] exp_q [$];

  function automatic logic [16:0] word_of(input logic [31:0] a);
    logic [31:0] t;
    t = a - 32'd1024;
    return t[18:2];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input string tag, input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d);
    int lat, we_lo;
    logic [31:0] e;
    @(negedge clk);
    wr_en = w; rd_en = r; address = a; wdata = d;
    if (w) ref_mem[word_of(a)] = d;
    else if (r) exp_q.push_back(ref_mem[word_of(a)]);
    #1;
    lat = 0; we_lo = 0;
    while (ready !== 1'b1 && lat < 40) begin
      if (SRAM_WE_N === 1'b0) we_lo++;
      @(negedge clk); #1;
      lat++;
    end
    check({tag, " ready-low cycles"}, 32'(lat), 32'd5);
    check({tag, " we_n-low cycles"}, 32'(we_lo), w ? 32'd2 : 32'd0);
    if (r && !w) begin
      e = exp_q.pop_front();
      check({tag, " rdata"}, rdata, e);
    end
  endtask

  task automatic read0(input string tag, input logic [31:0] a, input logic [17:0] lo);
    int lat;
    logic [17:0] lo_seen, hi_seen;
    @(negedge clk);
    rd_en0 = 1'b1; address0 = a;
    exp_q.push_back({pat(lo | 18'd1), pat(lo)});
    #1;
    lat = 0; lo_seen = '0; hi_seen = '0;
    while (ready0 !== 1'b1 && lat < 40) begin
      if (lat == 1) lo_seen = addr0;
      if (lat == 2) hi_seen = addr0;
      @(negedge clk); #1;
      lat++;
    end
    check({tag, " ready-low cycles"}, 32'(lat), 32'd3);
    check({tag, " low addr"}, 32'(lo_seen), 32'(lo));
    check({tag, " high addr"}, 32'(hi_seen), 32'(lo | 18'd1));
    check({tag, " rdata"}, rdata0, exp_q.pop_front());
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      wr_en = 1'b0; rd_en = 1'b0; rd_en0 = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; wdata = '0;
    wr_en0 = 1'b0; rd_en0 = 1'b0; address0 = '0; wdata0 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset ready", 32'(ready), 32'd1);
    check("reset we_n", 32'(SRAM_WE_N), 32'd1);
    check("reset sram_addr", 32'(SRAM_ADDR), 32'd0);
    check("reset rdata", rdata, 32'd0);
    check("tie-offs", {28'd0, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N}, 32'd0);
    check("reset ready0", 32'(ready0), 32'd1);

    access("write 0x404", 1'b1, 1'b0, 32'h404, 32'hDEADBEEF);
    idle(1);
    check("sram[2]", 32'(mem[2]), 32'h0000BEEF);
    check("sram[3]", 32'(mem[3]), 32'h0000DEAD);
    access("read 0x404", 1'b0, 1'b1, 32'h404, 32'h0);
    idle(2);

    // Requests held continuously: each sequence starts the cycle after DONE.
    access("b2b read", 1'b0, 1'b1, 32'h404, 32'h0);
    access("b2b write", 1'b1, 1'b0, 32'h408, 32'hCAFEF00D);
    access("b2b readback", 1'b0, 1'b1, 32'h408, 32'h0);
    idle(1);
    check("sram[4]", 32'(mem[4]), 32'h0000F00D);
    check("sram[5]", 32'(mem[5]), 32'h0000CAFE);

    access("rd+wr", 1'b1, 1'b1, 32'h400, 32'h12345678);
    idle(1);
    check("sram[0]", 32'(mem[0]), 32'h00005678);
    check("sram[1]", 32'(mem[1]), 32'h00001234);
    access("read base", 1'b0, 1'b1, 32'h400, 32'h0);

    // Reset during ACC_HI of a write: low half lands, high half does not.
    @(negedge clk); wr_en = 1'b1; rd_en = 1'b0; address = 32'h400; wdata = 32'hAAAA5555;
    @(negedge clk);
    @(negedge clk); rst = 1'b1; wr_en = 1'b0;
    @(negedge clk); #1;
    check("rst ready", 32'(ready), 32'd1);
    check("rst we_n", 32'(SRAM_WE_N), 32'd1);
    check("rst rdata", rdata, 32'd0);
    check("rst sram_addr", 32'(SRAM_ADDR), 32'd0);
    check("rst sram[1] kept", 32'(mem[1]), 32'h00001234);
    check("rst sram[0] partial", 32'(mem[0]), 32'h00005555);
    @(negedge clk); rst = 1'b0;
    ref_mem[17'd0] = 32'h12345555;
    access("read after rst", 1'b0, 1'b1, 32'h400, 32'h0);

    idle(3);
    check("rdata hold idle", rdata, 32'h12345555);
    access("write keeps rdata", 1'b1, 1'b0, 32'h410, 32'h01020304);
    check("rdata hold write", rdata, 32'h12345555);

    // Request dropped and inputs changed right after acceptance.
    @(negedge clk); wr_en = 1'b1; rd_en = 1'b0; address = 32'h40C; wdata = 32'h0BADCAFE;
    ref_mem[word_of(32'h40C)] = 32'h0BADCAFE;
    @(negedge clk); wr_en = 1'b0; address = 32'h500; wdata = 32'h0;
    #1;
    check("dropped ready", 32'(ready), 32'd1);
    idle(6);
    check("sram[6]", 32'(mem[6]), 32'h0000CAFE);
    check("sram[7]", 32'(mem[7]), 32'h00000BAD);
    access("read dropped", 1'b0, 1'b1, 32'h40C, 32'h0);
    idle(2);

    read0("w0 base", 32'h400, 18'h00000);
    idle(1);
    read0("w0 wrap", 32'h3FC, 18'h3FFFE);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
